// File: rtl/display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_pkg                                                              |
// | Shared mode encodings, 480p60 default timing, and stage-0 bundle layout. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package display_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Sync flags are carried as logical "asserted"; polarity is applied at the pins.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       sof;
        logic       sol;
        logic [2:0] bar;
        logic       grid;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delay_line                                                               |
// | Async-reset shift register of DEPTH stages; DEPTH=0 is a pass-through.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst_n};
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/display_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_pipeline                                                         |
// | Pixel timing, sync re-alignment with shaded pixels, test-pattern mux.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module display_pipeline
    import display_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int COLOR_BITS = 4,
    parameter int PIPE_LAT   = 2,
    parameter int SYNC_POL   = 0,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic                  clk_pix,
    input  logic                  resetn,
    input  logic [1:0]            mode,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic                  de,
    input  logic [COLOR_BITS-1:0] pix_r,
    input  logic [COLOR_BITS-1:0] pix_g,
    input  logic [COLOR_BITS-1:0] pix_b,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  frame_start,
    output logic                  line_start
);

    localparam logic [XW-1:0] c_H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] c_V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] c_H_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] c_V_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] c_HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] c_HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] c_VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] c_VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XW-1:0] c_BAR_W    = XW'(H_ACTIVE / 8);
    localparam logic          c_POL      = (SYNC_POL != 0);

    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    mode_e                 r_mode_q;
    mode_e                 w_mode_eff;
    bundle_t               w_b0;
    bundle_t               w_bd;
    logic [BUNDLE_W-1:0]   w_bd_raw;
    logic [COLOR_BITS-1:0] w_r;
    logic [COLOR_BITS-1:0] w_g;
    logic [COLOR_BITS-1:0] w_b;

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == c_H_LAST) begin
            r_x <= '0;
            r_y <= (r_y == c_V_LAST) ? '0 : r_y + 1'b1;
        end else begin
            r_x <= r_x + 1'b1;
        end
    end

    assign x  = r_x;
    assign y  = r_y;
    assign de = w_b0.de;

    always_comb begin
        w_b0.de   = (r_x < c_H_ACT) && (r_y < c_V_ACT);
        w_b0.hs   = (r_x >= c_HS_START) && (r_x < c_HS_END);
        w_b0.vs   = (r_y >= c_VS_START) && (r_y < c_VS_END);
        w_b0.sof  = (r_x == '0) && (r_y == '0);
        w_b0.sol  = (r_x == '0) && w_b0.de;
        w_b0.bar  = 3'(r_x / c_BAR_W);
        w_b0.grid = (4'(r_x) == 4'd0) || (4'(r_y) == 4'd0);
    end

    delay_line #(
        .WIDTH     (BUNDLE_W),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL ({BUNDLE_W{1'b0}})
    ) u_bundle_dly (
        .clk   (clk_pix),
        .rst_n (resetn),
        .d     (w_b0),
        .q     (w_bd_raw)
    );

    assign w_bd = bundle_t'(w_bd_raw);

    // Mode only changes at frame origin so a frame never mixes two patterns.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_mode_q <= MODE_PASS;
        end else if (w_b0.sof) begin
            r_mode_q <= mode_e'(mode);
        end
    end

    // With no delay, pixel (0,0) is muxed on the very edge that latches the mode.
    assign w_mode_eff = (PIPE_LAT == 0 && w_b0.sof) ? mode_e'(mode) : r_mode_q;

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_bd.de) begin
            case (w_mode_eff)
                MODE_PASS: begin
                    w_r = pix_r;
                    w_g = pix_g;
                    w_b = pix_b;
                end
                MODE_BARS: begin
                    w_b = {COLOR_BITS{w_bd.bar[0]}};
                    w_r = {COLOR_BITS{w_bd.bar[1]}};
                    w_g = {COLOR_BITS{w_bd.bar[2]}};
                end
                MODE_GRID: begin
                    w_r = {COLOR_BITS{w_bd.grid}};
                    w_g = {COLOR_BITS{w_bd.grid}};
                    w_b = {COLOR_BITS{w_bd.grid}};
                end
                default: begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= ~c_POL;
            vga_vsync   <= ~c_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_r       <= w_r;
            vga_g       <= w_g;
            vga_b       <= w_b;
            vga_hsync   <= w_bd.hs ? c_POL : ~c_POL;
            vga_vsync   <= w_bd.vs ? c_POL : ~c_POL;
            frame_start <= w_bd.sof;
            line_start  <= w_bd.sol;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_pipeline                                                      |
// | Two small-timing builds (latency 3 / active-low, latency 1 / active-high)|
// | checked every cycle against an independent raster model.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_display_pipeline;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        clk_pix = 1'b0;
    logic        resetn;
    logic [1:0]  mode;
    logic        rnd;
    logic [11:0] rand_v;

    logic [3:0] x0, x1;
    logic [2:0] y0, y1;
    logic       de0, de1;
    logic [3:0] pr0, pg0, pb0, pr1, pg1, pb1;
    logic [3:0] vr0, vg0, vb0, vr1, vg1, vb1;
    logic       hs0, vs0, fs0, ls0, hs1, vs1, fs1, ls1;
    logic [3:0] xd1, xd2;
    logic [2:0] yd1, yd2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int frame_mode [8];

    always #5 clk_pix = ~clk_pix;

    // Upstream shader model: returns (x, y, ~x) of the pixel issued two cycles earlier.
    always @(posedge clk_pix) begin
        xd1    <= x0;
        xd2    <= xd1;
        yd1    <= y0;
        yd2    <= yd1;
        rand_v <= 12'($urandom);
    end

    assign pr0 = rnd ? rand_v[3:0]  : xd2;
    assign pg0 = rnd ? rand_v[7:4]  : {1'b0, yd2};
    assign pb0 = rnd ? rand_v[11:8] : ~xd2;
    assign pr1 = rnd ? rand_v[3:0]  : x1;
    assign pg1 = rnd ? rand_v[7:4]  : {1'b0, y1};
    assign pb1 = rnd ? rand_v[11:8] : ~x1;

    display_pipeline #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(4), .PIPE_LAT(2), .SYNC_POL(0)
    ) u_dut0 (
        .clk_pix(clk_pix), .resetn(resetn), .mode(mode),
        .x(x0), .y(y0), .de(de0),
        .pix_r(pr0), .pix_g(pg0), .pix_b(pb0),
        .vga_r(vr0), .vga_g(vg0), .vga_b(vb0),
        .vga_hsync(hs0), .vga_vsync(vs0),
        .frame_start(fs0), .line_start(ls0)
    );

    display_pipeline #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(4), .PIPE_LAT(0), .SYNC_POL(1)
    ) u_dut1 (
        .clk_pix(clk_pix), .resetn(resetn), .mode(mode),
        .x(x1), .y(y1), .de(de1),
        .pix_r(pr1), .pix_g(pg1), .pix_b(pb1),
        .vga_r(vr1), .vga_g(vg1), .vga_b(vb1),
        .vga_hsync(hs1), .vga_vsync(vs1),
        .frame_start(fs1), .line_start(ls1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int lat, input bit pol,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input logic hs, input logic vs, input logic fs, input logic ls);
        int         p, px, py, m;
        bit         act;
        logic [3:0] er, eg, eb;
        logic       ehs, evs, efs, els;
        p   = cyc - lat;
        er  = 4'h0;
        eg  = 4'h0;
        eb  = 4'h0;
        ehs = !pol;
        evs = !pol;
        efs = 1'b0;
        els = 1'b0;
        if (p >= 0) begin
            px  = p % HT;
            py  = (p / HT) % VT;
            act = (px < 8) && (py < 4);
            ehs = (px >= 10 && px < 12) ? pol : !pol;
            evs = (py == 5) ? pol : !pol;
            efs = (px == 0) && (py == 0);
            els = (px == 0) && act;
            if (act) begin
                m = frame_mode[p / FT];
                case (m)
                    0: begin
                        er = 4'(px);
                        eg = 4'(py);
                        eb = ~4'(px);
                    end
                    1: begin
                        eb = px[0] ? 4'hF : 4'h0;
                        er = px[1] ? 4'hF : 4'h0;
                        eg = px[2] ? 4'hF : 4'h0;
                    end
                    2: begin
                        if (px == 0 || py == 0) begin
                            er = 4'hF;
                            eg = 4'hF;
                            eb = 4'hF;
                        end
                    end
                    default: ;
                endcase
            end
        end
        check_eq({tag, "_r"},  32'(r),  32'(er));
        check_eq({tag, "_g"},  32'(g),  32'(eg));
        check_eq({tag, "_b"},  32'(b),  32'(eb));
        check_eq({tag, "_hs"}, 32'(hs), 32'(ehs));
        check_eq({tag, "_vs"}, 32'(vs), 32'(evs));
        check_eq({tag, "_fs"}, 32'(fs), 32'(efs));
        check_eq({tag, "_ls"}, 32'(ls), 32'(els));
    endtask

    task automatic step();
        @(negedge clk_pix);
        check_eq("x0",  32'(x0),  32'(cyc % HT));
        check_eq("y0",  32'(y0),  32'((cyc / HT) % VT));
        check_eq("de0", 32'(de0), 32'(((cyc % HT) < 8) && (((cyc / HT) % VT) < 4)));
        check_eq("x1",  32'(x1),  32'(cyc % HT));
        check_dut("d0", 3, 1'b0, vr0, vg0, vb0, hs0, vs0, fs0, ls0);
        check_dut("d1", 1, 1'b1, vr1, vg1, vb1, hs1, vs1, fs1, ls1);
        case (cyc)
            17:  mode = 2'd1;
            120: mode = 2'd2;
            200: mode = 2'd3;
            294: rnd  = 1'b1;
            300: mode = 2'd0;
            392: rnd  = 1'b0;
            default: ;
        endcase
        if (cyc % FT == 0) frame_mode[cyc / FT] = int'(mode);
        cyc++;
    endtask

    initial begin
        resetn = 1'b0;
        mode   = 2'd0;
        rnd    = 1'b0;
        for (int i = 0; i < 8; i++) frame_mode[i] = 0;
        repeat (3) @(posedge clk_pix);
        #2 resetn = 1'b1;
        cyc = 0;
        repeat (511) step();

        // Asynchronous reset in the middle of an active line.
        #1 resetn = 1'b0;
        #1;
        check_eq("rst_x0",  32'(x0),  32'd0);
        check_eq("rst_r0",  32'(vr0), 32'd0);
        check_eq("rst_g0",  32'(vg0), 32'd0);
        check_eq("rst_b0",  32'(vb0), 32'd0);
        check_eq("rst_hs0", 32'(hs0), 32'd1);
        check_eq("rst_vs0", 32'(vs0), 32'd1);
        check_eq("rst_fs0", 32'(fs0), 32'd0);
        check_eq("rst_ls0", 32'(ls0), 32'd0);
        check_eq("rst_r1",  32'(vr1), 32'd0);
        check_eq("rst_hs1", 32'(hs1), 32'd0);
        check_eq("rst_vs1", 32'(vs1), 32'd0);
        repeat (2) @(posedge clk_pix);
        #2 resetn = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) frame_mode[i] = 0;
        repeat (120) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
